lsu: RTL and testbench

Load/store unit between the execute stage and the `MMU` memory port. It turns RISC-V byte, halfword and word loads and stores into the word-wide `op`/`rw`/`addr`/`data_w`/`data_r` accesses that the `MMU` accepts. Loads are sign- or zero-extended. Sub-word stores are done by read-modify-write. Misaligned or illegal requests are rejected without touching memory.

---
 rtl/lsu.sv | 204 ++++++++++++++++++++
 tb/tb_lsu.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit bridging execute-stage requests to the word-wide MMU port
//
// Purpose: turns B/H/W/BU/HU loads and B/H/W stores into aligned word accesses.
// Loads are sign/zero-extended, sub-word stores are done by read-modify-write.
// Misaligned or illegal requests are answered with rsp_err without any memory access.
//
// Ports:
//   sys_clk, sys_rst                  clock, asynchronous active-high reset
//   req_valid/req_ready               request handshake (ready only in IDLE)
//   req_we, req_funct3                store flag, access type
//   req_addr, req_wdata               byte address, store data (low bits)
//   rsp_valid, rsp_err, rsp_rdata     one-cycle completion pulse with status and load data
//   mem_op, mem_rw, mem_addr          MMU command, direction, word-aligned address
//   mem_data_w, mem_data_r            MMU write data, read data (valid the cycle after a read)
module lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  mem_op,
    output logic                  mem_rw,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_w,
    input  logic [DATA_WIDTH-1:0] mem_data_r
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        RWAIT = 3'd2,
        WR    = 3'd3,
        RSP   = 3'd4
    } state_t;

    state_t                  state;
    logic                    we_q;
    logic [2:0]              f3_q;
    logic [1:0]              lane_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    logic                    bad;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic [DATA_WIDTH-1:0]   load_ext;
    logic [DATA_WIDTH-1:0]   merged;

    // Legality of the incoming request; only consulted on the acceptance edge.
    always_comb begin
        bad = 1'b0;
        case (req_funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = req_addr[0];
            F3_W:    bad = (req_addr[1:0] != 2'b00);
            F3_BU:   bad = req_we;
            F3_HU:   bad = req_we | req_addr[0];
            default: bad = 1'b1;
        endcase
    end

    // The read word is consumed on the edge that ends RWAIT, so the extracted
    // load result and the merged store word are registered straight from mem_data_r.
    always_comb begin
        byte_sel = mem_data_r[7:0];
        case (lane_q)
            2'd0:    byte_sel = mem_data_r[7:0];
            2'd1:    byte_sel = mem_data_r[15:8];
            2'd2:    byte_sel = mem_data_r[23:16];
            default: byte_sel = mem_data_r[31:24];
        endcase
        half_sel = lane_q[1] ? mem_data_r[31:16] : mem_data_r[15:0];

        load_ext = mem_data_r;
        case (f3_q)
            F3_B:    load_ext = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_BU:   load_ext = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            F3_H:    load_ext = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            F3_HU:   load_ext = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_ext = mem_data_r;
        endcase

        merged = mem_data_r;
        case (f3_q)
            F3_B: begin
                case (lane_q)
                    2'd0:    merged[7:0]   = wdata_q[7:0];
                    2'd1:    merged[15:8]  = wdata_q[7:0];
                    2'd2:    merged[23:16] = wdata_q[7:0];
                    default: merged[31:24] = wdata_q[7:0];
                endcase
            end
            F3_H: begin
                if (lane_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            mem_op     <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            mem_data_w <= '0;
            we_q       <= 1'b0;
            f3_q       <= '0;
            lane_q     <= '0;
            wdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q      <= req_we;
                        f3_q      <= req_funct3;
                        lane_q    <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        req_ready <= 1'b0;
                        if (bad) begin
                            state     <= RSP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (req_we && req_funct3 == F3_W) begin
                            // Full-word store needs no read; go straight to the write.
                            state      <= WR;
                            mem_op     <= 1'b1;
                            mem_rw     <= 1'b1;
                            mem_data_w <= req_wdata;
                        end else begin
                            state  <= RD;
                            mem_op <= 1'b1;
                            mem_rw <= 1'b0;
                        end
                    end
                end
                RD: begin
                    state  <= RWAIT;
                    mem_op <= 1'b0;
                    mem_rw <= 1'b0;
                end
                RWAIT: begin
                    if (we_q) begin
                        state      <= WR;
                        mem_op     <= 1'b1;
                        mem_rw     <= 1'b1;
                        mem_data_w <= merged;
                    end else begin
                        state     <= RSP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_ext;
                    end
                end
                WR: begin
                    state     <= RSP;
                    mem_op    <= 1'b0;
                    mem_rw    <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                RSP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    mem_op    <= 1'b0;
                    mem_rw    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu against a word memory model
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_op;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_w;
    logic [31:0] mem_data_r;

    always #5 clk = ~clk;

    lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .sys_clk    (clk),
        .sys_rst    (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .mem_op     (mem_op),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_data_w (mem_data_w),
        .mem_data_r (mem_data_r)
    );

    // Word memory: synchronous read returns data the cycle after the read command.
    logic [31:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'hDEADBEEF;
        mem[8'h42] = 32'hDEADBEEF;
        mem_data_r = 32'h0;
        forever begin
            @(posedge clk);
            if (mem_op) begin
                if (mem_rw) mem[mem_addr[9:2]] <= mem_data_w;
                else        mem_data_r <= mem[mem_addr[9:2]];
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;

    int          lat, n_rd, n_wr, rd_at, wr_at, n_rsp, guard;
    logic [31:0] rd_addr, wr_addr, wr_data, r_data;
    logic        r_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, then watch 12 cycles; cycle n=1 is the one after acceptance.
    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("accept", 32'(guard < 20), 32'd1);
        lat = -1; n_rd = 0; n_wr = 0; rd_at = -1; wr_at = -1; n_rsp = 0;
        rd_addr = '0; wr_addr = '0; wr_data = '0; r_data = 32'hX; r_err = 1'bX;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b111; req_addr = 32'h3FF; req_wdata = '1;
        for (int n = 1; n <= 12; n++) begin
            if (mem_op) begin
                if (mem_rw) begin n_wr++; wr_at = n; wr_addr = mem_addr; wr_data = mem_data_w; end
                else        begin n_rd++; rd_at = n; rd_addr = mem_addr; end
            end
            if (rsp_valid) begin
                n_rsp++;
                if (lat < 0) begin lat = n; r_data = rsp_rdata; r_err = rsp_err; end
            end
            if (n < 12) @(negedge clk);
        end
    endtask

    task automatic check_load(input string tag, input logic [31:0] exp);
        check({tag, " rdata"}, r_data, exp);
        check({tag, " err"}, 32'(r_err), 32'd0);
        check({tag, " latency"}, lat, 32'd3);
        check({tag, " reads"}, n_rd, 32'd1);
        check({tag, " read_at"}, rd_at, 32'd1);
        check({tag, " writes"}, n_wr, 32'd0);
        check({tag, " rsp_pulses"}, n_rsp, 32'd1);
    endtask

    task automatic check_err(input string tag);
        check({tag, " err"}, 32'(r_err), 32'd1);
        check({tag, " latency"}, lat, 32'd1);
        check({tag, " rdata"}, r_data, 32'd0);
        check({tag, " mem_ops"}, n_rd + n_wr, 32'd0);
    endtask

    int          rdy [1:4];
    int          rsp1_at, rsp2_at, pulses;
    logic [31:0] rsp1_data;

    initial begin
        // Reset state
        @(negedge clk);
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst mem_op", 32'(mem_op), 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle req_ready", 32'(req_ready), 32'd1);
        check("idle rsp_rdata", rsp_rdata, 32'd0);

        // Loads from 0x100 = 0xDEADBEEF
        run(1'b0, 3'b000, 32'h103, 32'h0);
        check_load("LB 0x103", 32'hFFFFFFDE);
        check("LB 0x103 mem_addr", rd_addr, 32'h100);
        run(1'b0, 3'b100, 32'h103, 32'h0);
        check_load("LBU 0x103", 32'h000000DE);
        run(1'b0, 3'b001, 32'h102, 32'h0);
        check_load("LH 0x102", 32'hFFFFDEAD);
        check("LH 0x102 mem_addr", rd_addr, 32'h100);
        run(1'b0, 3'b101, 32'h100, 32'h0);
        check_load("LHU 0x100", 32'h0000BEEF);
        run(1'b0, 3'b000, 32'h100, 32'h0);
        check_load("LB 0x100", 32'hFFFFFFEF);

        // Sub-word stores by read-modify-write
        run(1'b1, 3'b000, 32'h101, 32'hAAAAAA12);
        check("SB read_at", rd_at, 32'd1);
        check("SB write_at", wr_at, 32'd3);
        check("SB wdata", wr_data, 32'hDEAD12EF);
        check("SB waddr", wr_addr, 32'h100);
        check("SB latency", lat, 32'd4);
        check("SB err", 32'(r_err), 32'd0);
        check("SB rdata", r_data, 32'd0);
        check("SB writes", n_wr, 32'd1);
        check("SB mem", mem[8'h40], 32'hDEAD12EF);
        run(1'b1, 3'b001, 32'h10A, 32'h00005566);
        check("SH wdata", wr_data, 32'h5566BEEF);
        check("SH latency", lat, 32'd4);
        check("SH mem", mem[8'h42], 32'h5566BEEF);

        // Word store and readback
        run(1'b1, 3'b010, 32'h104, 32'hCAFEBABE);
        check("SW reads", n_rd, 32'd0);
        check("SW writes", n_wr, 32'd1);
        check("SW write_at", wr_at, 32'd1);
        check("SW wdata", wr_data, 32'hCAFEBABE);
        check("SW waddr", wr_addr, 32'h104);
        check("SW latency", lat, 32'd2);
        check("SW err", 32'(r_err), 32'd0);
        run(1'b0, 3'b010, 32'h104, 32'h0);
        check_load("LW 0x104", 32'hCAFEBABE);

        // Illegal / misaligned
        run(1'b0, 3'b010, 32'h102, 32'h0);
        check_err("LW 0x102");
        run(1'b1, 3'b001, 32'h101, 32'h1234);
        check_err("SH 0x101");
        run(1'b1, 3'b100, 32'h100, 32'h55);
        check_err("SBU store");
        run(1'b0, 3'b011, 32'h100, 32'h0);
        check_err("funct3 011");
        check("err no write mem", mem[8'h40], 32'hDEAD12EF);

        // Reset during RWAIT of SB 0x100
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h100; req_wdata = 32'h77;
        check("rstmid ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("rstmid RD op", 32'(mem_op), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid req_ready", 32'(req_ready), 32'd1);
        check("rstmid mem_op", 32'(mem_op), 32'd0);
        check("rstmid rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstmid mem_addr", mem_addr, 32'd0);
        check("rstmid mem_data_w", mem_data_w, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (rsp_valid || mem_op) pulses++;
        end
        check("rstmid no activity", pulses, 32'd0);
        check("rstmid mem", mem[8'h40], 32'hDEAD12EF);
        run(1'b0, 3'b010, 32'h100, 32'h0);
        check_load("LW after rst", 32'hDEAD12EF);

        // Back-to-back with req_valid held high
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h104; req_wdata = 32'h0;
        check("b2b ready0", 32'(req_ready), 32'd1);
        rsp1_at = -1; rsp2_at = -1; pulses = 0; rsp1_data = '0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) begin
                req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10C; req_wdata = 32'h11223344;
            end
            if (n == 5) req_valid = 1'b0;
            if (n <= 4) rdy[n] = int'(req_ready);
            if (rsp_valid) begin
                pulses++;
                if (rsp1_at < 0) begin rsp1_at = n; rsp1_data = rsp_rdata; end
                else rsp2_at = n;
            end
        end
        check("b2b ready T+1", rdy[1], 32'd0);
        check("b2b ready T+2", rdy[2], 32'd0);
        check("b2b ready T+3", rdy[3], 32'd0);
        check("b2b ready T+4", rdy[4], 32'd1);
        check("b2b rsp1 at", rsp1_at, 32'd3);
        check("b2b rsp1 data", rsp1_data, 32'hCAFEBABE);
        check("b2b rsp2 at", rsp2_at, 32'd6);
        check("b2b pulses", pulses, 32'd2);
        check("b2b mem", mem[8'h43], 32'h11223344);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
